selfadd_frame_feeder: RTL

- Upstream issue stage for the 16bx2 self-add accumulator.
- Buffers incoming lane pairs in a small FIFO and issues them to the accumulator no faster than its adder pipeline permits.
- Counts a frame of N accumulations, waits for the final accumulated result, and presents it downstream on a valid/ready port.
- Then pulses the accumulator's usr_rst to clear it for the next frame.

---
 rtl/selfadd_frame_feeder_pkg.sv | 22 ++
 rtl/selfadd_frame_feeder_if.sv | 39 +++
 rtl/selfadd_feed_fifo.sv | 68 ++++++
 rtl/selfadd_frame_feeder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/selfadd_frame_feeder_pkg.sv
// Shared types and default constants for the self-add frame feeder.
package selfadd_frame_feeder_pkg;

    localparam int LANE_W         = 16;
    localparam int PAIR_W         = 2 * LANE_W;
    localparam int DEF_ISSUE_GAP  = 4;
    localparam int DEF_CLR_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [LANE_W-1:0] a;
        logic [LANE_W-1:0] b;
    } pair_t;

endpackage

// File: rtl/selfadd_frame_feeder_if.sv
// Bundle of the feeder's input, accumulator and output ports; master is the feeder side.
interface selfadd_frame_feeder_if
    import selfadd_frame_feeder_pkg::*;
#(
    parameter int LEN_W = 8
);
    logic [LEN_W-1:0]  cfg_frame_len;
    logic              in_v;
    logic              in_rdy;
    logic [LANE_W-1:0] in_data_a;
    logic [LANE_W-1:0] in_data_b;
    logic              acc_data_v;
    logic [LANE_W-1:0] acc_data_a;
    logic [LANE_W-1:0] acc_data_b;
    logic              acc_usr_rst;
    logic              acc_res_v;
    logic [LANE_W-1:0] acc_res_a;
    logic [LANE_W-1:0] acc_res_b;
    logic              out_v;
    logic              out_rdy;
    logic [LANE_W-1:0] out_data_a;
    logic [LANE_W-1:0] out_data_b;
    logic              busy;

    modport master (
        input  cfg_frame_len, in_v, in_data_a, in_data_b,
        input  acc_res_v, acc_res_a, acc_res_b, out_rdy,
        output in_rdy, acc_data_v, acc_data_a, acc_data_b, acc_usr_rst,
        output out_v, out_data_a, out_data_b, busy
    );

    modport slave (
        output cfg_frame_len, in_v, in_data_a, in_data_b,
        output acc_res_v, acc_res_a, acc_res_b, out_rdy,
        input  in_rdy, acc_data_v, acc_data_a, acc_data_b, acc_usr_rst,
        input  out_v, out_data_a, out_data_b, busy
    );

endinterface

// File: rtl/selfadd_feed_fifo.sv
// Synchronous FIFO with registered flags and registered read data (no fall-through).
// o_can_push is low while in reset and whenever the FIFO is full.
module selfadd_feed_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_can_push,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nx;
    logic [W-1:0]  r_dout;
    logic          r_can_push;
    logic          r_empty;

    always_comb begin
        w_cnt_nx = r_cnt;
        if (i_push && !i_pop) begin
            w_cnt_nx = r_cnt + 1'b1;
        end else if (!i_push && i_pop) begin
            w_cnt_nx = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_can_push <= 1'b0;
            r_empty    <= 1'b1;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_cnt      <= w_cnt_nx;
            r_can_push <= (w_cnt_nx != (AW+1)'(DEPTH));
            r_empty    <= (w_cnt_nx == '0);
        end
    end

    assign o_dout     = r_dout;
    assign o_can_push = r_can_push;
    assign o_empty    = r_empty;

endmodule

// File: rtl/selfadd_frame_feeder.sv
// Issues buffered lane pairs to the self-add accumulator at most once per ISSUE_GAP cycles,
// returns the frame sum on out_v/out_rdy (held until taken), then clears the accumulator.
module selfadd_frame_feeder
    import selfadd_frame_feeder_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ISSUE_GAP  = DEF_ISSUE_GAP,
    parameter int LEN_W      = 8,
    parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
    input logic                    clk,
    input logic                    rst,
    selfadd_frame_feeder_if.master bus
);
    localparam int GAP_W = $clog2(ISSUE_GAP + 1);
    localparam int CLR_W = $clog2(CLR_CYCLES + 1);

    state_t            r_state;
    state_t            w_state_nx;
    pair_t             w_in_pair;
    pair_t             w_fifo_dout;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_can_push;
    logic              w_fifo_empty;
    logic              w_res_cnt_en;
    logic              w_res_last;
    logic [LEN_W-1:0]  w_issue_inc;
    logic [LEN_W-1:0]  w_res_inc;
    logic [LEN_W-1:0]  w_len_cfg;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issue_cnt;
    logic [LEN_W-1:0]  r_res_cnt;
    logic [GAP_W-1:0]  r_gap;
    logic [CLR_W-1:0]  r_clr_cnt;
    logic              r_pop_q;
    logic              r_acc_data_v;
    pair_t             r_acc_data;
    logic              r_acc_usr_rst;
    logic              r_out_v;
    pair_t             r_out_data;
    logic              r_busy;

    assign w_in_pair = {bus.in_data_a, bus.in_data_b};
    assign w_push    = bus.in_v && w_fifo_can_push;
    assign w_len_cfg = (bus.cfg_frame_len == '0) ? LEN_W'(1) : bus.cfg_frame_len;

    selfadd_feed_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (PAIR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .i_push     (w_push),
        .i_din      (w_in_pair),
        .i_pop      (w_pop),
        .o_dout     (w_fifo_dout),
        .o_can_push (w_fifo_can_push),
        .o_empty    (w_fifo_empty)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_pop        = 1'b0;
        w_res_last   = 1'b0;
        w_issue_inc  = r_issue_cnt + 1'b1;
        w_res_inc    = r_res_cnt + 1'b1;
        w_res_cnt_en = bus.acc_res_v && (r_state == ST_ISSUE || r_state == ST_DRAIN);
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) w_state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!w_fifo_empty && r_gap == '0) begin
                    w_pop = 1'b1;
                    if (w_issue_inc == r_len) w_state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_res_cnt_en && w_res_inc == r_len) begin
                    w_res_last = 1'b1;
                    w_state_nx = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_rdy) w_state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_res_cnt     <= '0;
            r_gap         <= '0;
            r_clr_cnt     <= '0;
            r_pop_q       <= 1'b0;
            r_acc_data_v  <= 1'b0;
            r_acc_data    <= '0;
            r_acc_usr_rst <= 1'b0;
            r_out_v       <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_state_nx == ST_ISSUE) begin
                r_len       <= w_len_cfg;
                r_issue_cnt <= '0;
                r_res_cnt   <= '0;
                r_gap       <= '0;
            end else begin
                if (w_pop) begin
                    r_gap       <= GAP_W'(ISSUE_GAP - 1);
                    r_issue_cnt <= w_issue_inc;
                end else if (r_gap != '0) begin
                    r_gap <= r_gap - 1'b1;
                end
                if (w_res_cnt_en) r_res_cnt <= w_res_inc;
            end
            // The FIFO read register lands one cycle after the pop, so the strobe trails by one stage.
            r_pop_q      <= w_pop;
            r_acc_data_v <= r_pop_q;
            if (r_pop_q) r_acc_data <= w_fifo_dout;
            if (w_res_last) begin
                r_out_v    <= 1'b1;
                r_out_data <= {bus.acc_res_a, bus.acc_res_b};
            end else if (r_state == ST_OUTPUT && bus.out_rdy) begin
                r_out_v <= 1'b0;
            end
            r_clr_cnt     <= (r_state == ST_CLEAR) ? r_clr_cnt + 1'b1 : '0;
            r_acc_usr_rst <= (w_state_nx == ST_CLEAR);
            r_busy        <= (w_state_nx != ST_IDLE);
        end
    end

    assign bus.in_rdy      = w_fifo_can_push;
    assign bus.acc_data_v  = r_acc_data_v;
    assign bus.acc_data_a  = r_acc_data.a;
    assign bus.acc_data_b  = r_acc_data.b;
    assign bus.acc_usr_rst = r_acc_usr_rst;
    assign bus.out_v       = r_out_v;
    assign bus.out_data_a  = r_out_data.a;
    assign bus.out_data_b  = r_out_data.b;
    assign bus.busy        = r_busy;

endmodule
